dmem_ctrl: RTL and testbench

- Requester-side controller for the dual-port data SRAM (port 0 write-only, port 1 read-only, 256 x 32, byte write mask).
- Accepts byte-addressed load/store requests from the LSU over a valid/ready handshake.
- Drives the SRAM chip-select, address, mask and data pins, captures read data, and returns sign- or zero-extended results on a valid/ready response channel.
- One request outstanding; misaligned and out-of-range accesses are rejected without touching the SRAM.

---
 rtl/dmem_ctrl_if.sv | 28 ++
 rtl/dmem_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_ctrl_if.sv
// LSU-side request/response channel of the data-memory controller.
// The master modport is the LSU side and the slave modport is the controller side.
interface dmem_ctrl_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REQ_ADDR_WIDTH = 32
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_we;
  logic [1:0]                req_size;
  logic                      req_signed;
  logic [REQ_ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0]     req_wdata;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [DATA_WIDTH-1:0]     resp_rdata;
  logic                      resp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Requester-side controller for a 1W/1R 256x32 data SRAM with byte write mask.
// Handles one LSU load/store at a time; every SRAM pin is driven from a register.
module dmem_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int NUM_WMASKS     = 4,
  parameter int REQ_ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  dmem_ctrl_if.slave            lsu,
  output logic                  csb0_o,
  output logic [NUM_WMASKS-1:0] wmask0_o,
  output logic [ADDR_WIDTH-1:0] addr0_o,
  output logic [DATA_WIDTH-1:0] din0_o,
  output logic                  csb1_o,
  output logic [ADDR_WIDTH-1:0] addr1_o,
  input  logic [DATA_WIDTH-1:0] dout1_i
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR     = 3'd1,
    RD     = 3'd2,
    RD_CAP = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;
  logic                  csb0_q, csb0_d;
  logic [NUM_WMASKS-1:0] wmask0_q, wmask0_d;
  logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
  logic [DATA_WIDTH-1:0] din0_q, din0_d;
  logic                  csb1_q, csb1_d;
  logic [ADDR_WIDTH-1:0] addr1_q, addr1_d;
  logic [1:0]            off_q, off_d;
  logic [1:0]            size_q, size_d;
  logic                  sgn_q, sgn_d;
  logic                  err_s;
  logic                  accept_s;

  function automatic logic [NUM_WMASKS-1:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    lane_mask = 4'b0001 << off;
      2'd1:    lane_mask = off[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] lane_data(input logic [1:0] size, input logic [DATA_WIDTH-1:0] wdata);
    case (size)
      2'd0:    lane_data = {4{wdata[7:0]}};
      2'd1:    lane_data = {2{wdata[15:0]}};
      default: lane_data = wdata;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [DATA_WIDTH-1:0] word,
                                                        input logic [1:0] size,
                                                        input logic [1:0] off,
                                                        input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'd0:    load_extend = {{24{sgn & b[7]}}, b};
      2'd1:    load_extend = {{16{sgn & h[15]}}, h};
      default: load_extend = word;
    endcase
  endfunction

  assign accept_s = lsu.req_valid && req_ready_q;
  assign err_s = (lsu.req_size == 2'd3)
              || ((lsu.req_size == 2'd1) && lsu.req_addr[0])
              || ((lsu.req_size == 2'd2) && (lsu.req_addr[1:0] != 2'b00))
              || (|lsu.req_addr[REQ_ADDR_WIDTH-1:ADDR_WIDTH+2]);

  // Next-state and next-output logic for the request sequencer.
  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    csb0_d       = csb0_q;
    wmask0_d     = wmask0_q;
    addr0_d      = addr0_q;
    din0_d       = din0_q;
    csb1_d       = csb1_q;
    addr1_d      = addr1_q;
    off_d        = off_q;
    size_d       = size_q;
    sgn_d        = sgn_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          off_d       = lsu.req_addr[1:0];
          size_d      = lsu.req_size;
          sgn_d       = lsu.req_signed;
          req_ready_d = 1'b0;
          if (err_s) begin
            // Rejected accesses never touch the SRAM pins.
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
            resp_valid_d = 1'b1;
            state_d      = RESP;
          end else if (lsu.req_we) begin
            csb0_d   = 1'b0;
            addr0_d  = lsu.req_addr[ADDR_WIDTH+1:2];
            wmask0_d = lane_mask(lsu.req_size, lsu.req_addr[1:0]);
            din0_d   = lane_data(lsu.req_size, lsu.req_wdata);
            state_d  = WR;
          end else begin
            csb1_d  = 1'b0;
            addr1_d = lsu.req_addr[ADDR_WIDTH+1:2];
            state_d = RD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WR: begin
        csb0_d       = 1'b1;
        wmask0_d     = '0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RD: begin
        csb1_d  = 1'b1;
        state_d = RD_CAP;
      end
      RD_CAP: begin
        resp_rdata_d = load_extend(dout1_i, size_q, off_q, sgn_q);
        resp_err_d   = 1'b0;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (resp_valid_q && lsu.resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d      = IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
        csb0_d       = 1'b1;
        csb1_d       = 1'b1;
        wmask0_d     = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      csb0_q       <= 1'b1;
      wmask0_q     <= '0;
      addr0_q      <= '0;
      din0_q       <= '0;
      csb1_q       <= 1'b1;
      addr1_q      <= '0;
      off_q        <= 2'b00;
      size_q       <= 2'b00;
      sgn_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      csb0_q       <= csb0_d;
      wmask0_q     <= wmask0_d;
      addr0_q      <= addr0_d;
      din0_q       <= din0_d;
      csb1_q       <= csb1_d;
      addr1_q      <= addr1_d;
      off_q        <= off_d;
      size_q       <= size_d;
      sgn_q        <= sgn_d;
    end
  end

  assign lsu.req_ready  = req_ready_q;
  assign lsu.resp_valid = resp_valid_q;
  assign lsu.resp_rdata = resp_rdata_q;
  assign lsu.resp_err   = resp_err_q;
  assign csb0_o         = csb0_q;
  assign wmask0_o       = wmask0_q;
  assign addr0_o        = addr0_q;
  assign din0_o         = din0_q;
  assign csb1_o         = csb1_q;
  assign addr1_o        = addr1_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: behavioural SRAM, response scoreboard,
// a table of load/store vectors and hand-written timing/backpressure/reset sequences.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        csb0, csb1;
  logic [3:0]  wmask0;
  logic [7:0]  addr0, addr1;
  logic [31:0] din0;
  logic [31:0] dout1 = 32'h0;
  logic [31:0] mem [0:255];
  logic        sram_quiet = 1'b0;
  int          checks = 0;
  int          errors = 0;
  logic [32:0] exp_q [$];

  dmem_ctrl_if #(.DATA_WIDTH(32), .REQ_ADDR_WIDTH(32)) lsu_if ();

  dmem_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .lsu      (lsu_if.slave),
    .csb0_o   (csb0),
    .wmask0_o (wmask0),
    .addr0_o  (addr0),
    .din0_o   (din0),
    .csb1_o   (csb1),
    .addr1_o  (addr1),
    .dout1_i  (dout1)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: both ports sample on the rising edge.
  always @(posedge clk) begin
    if (!csb0) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask0[i]) mem[addr0][i*8 +: 8] <= din0[i*8 +: 8];
      end
    end
    if (!csb1) dout1 <= mem[addr1];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response scoreboard and SRAM chip-select checks.
  always @(negedge clk) begin
    if (!rst && lsu_if.resp_valid && lsu_if.resp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected response", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("resp_rdata", lsu_if.resp_rdata, e[31:0]);
        chk("resp_err", {31'd0, lsu_if.resp_err}, {31'd0, e[32]});
      end
    end
    if (!csb0 && !csb1) chk("csb0/csb1 both low", 32'd1, 32'd0);
    if (sram_quiet) chk("sram quiet on error", {30'd0, csb0, csb1}, 32'd3);
  end

  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
    int  n;
    logic ok;
    ok = 1'b0;
    n  = 0;
    @(negedge clk);
    lsu_if.req_we     = we;
    lsu_if.req_size   = size;
    lsu_if.req_signed = sgn;
    lsu_if.req_addr   = addr;
    lsu_if.req_wdata  = wdata;
    lsu_if.req_valid  = 1'b1;
    while (!ok && n < 50) begin
      if (lsu_if.req_ready) begin
        exp_q.push_back({exp_err, exp_rdata});
        ok = 1'b1;
        @(posedge clk);
        #1;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    lsu_if.req_valid = 1'b0;
    if (!ok) chk("accept timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("response timeout", exp_q.size(), 32'd0);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [3:0]  exp_wmask;
    logic [31:0] exp_din;
  } vec_t;

  vec_t vecs [21];

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    lsu_if.req_valid  = 1'b0;
    lsu_if.req_we     = 1'b0;
    lsu_if.req_size   = 2'd0;
    lsu_if.req_signed = 1'b0;
    lsu_if.req_addr   = 32'h0;
    lsu_if.req_wdata  = 32'h0;
    lsu_if.resp_ready = 1'b1;

    //             we    sz    sgn   addr          wdata         exp_rdata     err   wmask    din
    vecs[0]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0013, 32'h0000_0080, 32'h0000_0000, 1'b0, 4'b1000, 32'h8080_8080};
    vecs[1]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0013, 32'h0,         32'hFFFF_FF80, 1'b0, 4'b0000, 32'h0};
    vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0013, 32'h0,         32'h0000_0080, 1'b0, 4'b0000, 32'h0};
    vecs[3]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,         32'h80AD_BEEF, 1'b0, 4'b0000, 32'h0};
    vecs[4]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0020, 32'hCAFE_F00D, 32'h0000_0000, 1'b0, 4'b1111, 32'hCAFE_F00D};
    vecs[5]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0022, 32'hAAAA_1234, 32'h0000_0000, 1'b0, 4'b1100, 32'h1234_1234};
    vecs[6]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'h0,         32'h1234_F00D, 1'b0, 4'b0000, 32'h0};
    vecs[7]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0020, 32'h0,         32'hFFFF_F00D, 1'b0, 4'b0000, 32'h0};
    vecs[8]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0022, 32'h0,         32'h0000_1234, 1'b0, 4'b0000, 32'h0};
    vecs[9]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0021, 32'h0,         32'hFFFF_FFF0, 1'b0, 4'b0000, 32'h0};
    vecs[10] = '{1'b1, 2'd2, 1'b0, 32'h0000_03FC, 32'h55AA_00FF, 32'h0000_0000, 1'b0, 4'b1111, 32'h55AA_00FF};
    vecs[11] = '{1'b0, 2'd1, 1'b1, 32'h0000_03FE, 32'h0,         32'h0000_55AA, 1'b0, 4'b0000, 32'h0};
    vecs[12] = '{1'b0, 2'd0, 1'b1, 32'h0000_03FC, 32'h0,         32'hFFFF_FFFF, 1'b0, 4'b0000, 32'h0};
    vecs[13] = '{1'b0, 2'd2, 1'b0, 32'h0000_0002, 32'h0,         32'h0000_0000, 1'b1, 4'b0000, 32'h0};
    vecs[14] = '{1'b0, 2'd1, 1'b0, 32'h0000_0005, 32'h0,         32'h0000_0000, 1'b1, 4'b0000, 32'h0};
    vecs[15] = '{1'b0, 2'd3, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_0000, 1'b1, 4'b0000, 32'h0};
    vecs[16] = '{1'b0, 2'd2, 1'b0, 32'h0000_0400, 32'h0,         32'h0000_0000, 1'b1, 4'b0000, 32'h0};
    vecs[17] = '{1'b1, 2'd2, 1'b0, 32'h0000_0400, 32'h1111_1111, 32'h0000_0000, 1'b1, 4'b0000, 32'h0};
    vecs[18] = '{1'b1, 2'd1, 1'b0, 32'h0000_0001, 32'h2222_2222, 32'h0000_0000, 1'b1, 4'b0000, 32'h0};
    vecs[19] = '{1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_0000, 1'b0, 4'b0000, 32'h0};
    vecs[20] = '{1'b0, 2'd0, 1'b1, 32'h0000_03FF, 32'h0,         32'h0000_0055, 1'b0, 4'b0000, 32'h0};

    // Reset state.
    #12;
    chk("rst req_ready", {31'd0, lsu_if.req_ready}, 32'd1);
    chk("rst resp_valid", {31'd0, lsu_if.resp_valid}, 32'd0);
    chk("rst resp_rdata", lsu_if.resp_rdata, 32'd0);
    chk("rst resp_err", {31'd0, lsu_if.resp_err}, 32'd0);
    chk("rst csb", {30'd0, csb0, csb1}, 32'd3);
    chk("rst wmask0", {28'd0, wmask0}, 32'd0);
    chk("rst addr", {16'd0, addr0, addr1}, 32'd0);
    chk("rst din0", din0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Store word: one-cycle chip select, response the cycle after E1.
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
    chk("sw csb0", {31'd0, csb0}, 32'd0);
    chk("sw wmask0", {28'd0, wmask0}, 32'hF);
    chk("sw addr0", {24'd0, addr0}, 32'h04);
    chk("sw din0", din0, 32'hDEAD_BEEF);
    chk("sw req_ready busy", {31'd0, lsu_if.req_ready}, 32'd0);
    chk("sw resp_valid E0", {31'd0, lsu_if.resp_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("sw csb0 E1", {31'd0, csb0}, 32'd1);
    chk("sw wmask0 E1", {28'd0, wmask0}, 32'd0);
    chk("sw resp_valid E1", {31'd0, lsu_if.resp_valid}, 32'd1);
    wait_drain();

    // Load word: response valid after E0 + 2 edges.
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
    chk("lw csb1", {31'd0, csb1}, 32'd0);
    chk("lw addr1", {24'd0, addr1}, 32'h04);
    chk("lw resp_valid E0", {31'd0, lsu_if.resp_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("lw csb1 E1", {31'd0, csb1}, 32'd1);
    chk("lw resp_valid E1", {31'd0, lsu_if.resp_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("lw resp_valid E2", {31'd0, lsu_if.resp_valid}, 32'd1);
    wait_drain();

    // Table-driven vectors.
    for (int i = 0; i < 21; i++) begin
      sram_quiet = vecs[i].exp_err;
      issue(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
            vecs[i].exp_rdata, vecs[i].exp_err);
      if (vecs[i].exp_err) begin
        chk($sformatf("vec%0d csb idle", i), {30'd0, csb0, csb1}, 32'd3);
      end else if (vecs[i].we) begin
        chk($sformatf("vec%0d csb0", i), {31'd0, csb0}, 32'd0);
        chk($sformatf("vec%0d wmask0", i), {28'd0, wmask0}, {28'd0, vecs[i].exp_wmask});
        chk($sformatf("vec%0d din0", i), din0, vecs[i].exp_din);
      end else begin
        chk($sformatf("vec%0d csb1", i), {31'd0, csb1}, 32'd0);
      end
      wait_drain();
      sram_quiet = 1'b0;
    end

    // Backpressure: hold resp_ready low for 5 cycles.
    lsu_if.resp_ready = 1'b0;
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h80AD_BEEF, 1'b0);
    begin
      int n;
      n = 0;
      while (!lsu_if.resp_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp resp_valid", {31'd0, lsu_if.resp_valid}, 32'd1);
      chk("bp resp_rdata", lsu_if.resp_rdata, 32'h80AD_BEEF);
      chk("bp req_ready", {31'd0, lsu_if.req_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    lsu_if.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp req_ready after", {31'd0, lsu_if.req_ready}, 32'd1);
    chk("bp resp_valid after", {31'd0, lsu_if.resp_valid}, 32'd0);
    chk("bp scoreboard empty", exp_q.size(), 32'd0);

    // Reset asserted while in RD_CAP.
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h80AD_BEEF, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("rst mid csb1", {31'd0, csb1}, 32'd1);
    chk("rst mid resp_valid", {31'd0, lsu_if.resp_valid}, 32'd0);
    chk("rst mid req_ready", {31'd0, lsu_if.req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h80AD_BEEF, 1'b0);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
